local_predictor_pipe: RTL and testbench
=======================================

# local_predictor_pipe

Parametrised, pipelined local-history branch predictor for the tournament predictor's local side. A per-PC local history table (LHT) indexes a table of saturating counters (LPT). Compared with the fixed 10-bit local design, it adds:
- configurable PC, history and counter widths;
- valid/ready handshakes on separate predict and update ports;
- a registered two-stage predict pipeline;
- a post-reset table-initialisation sweep.

## Interface
- PC_BITS, 10, LHT index width; LHT has 2^PC_BITS entries
- HIST_BITS, 10, local history length; LPT has 2^HIST_BITS counters
- CTR_BITS, 3, LPT counter width (at least 2)
- clock  in  1  single clock, rising-edge
- reset  in  1  asynchronous, active-high
- pred_valid  in  1  predict request
- pred_pc  in  PC_BITS  predict index
- pred_ready  out  1  high only in RUN
- pred_out_valid  out  1  one-cycle strobe, result valid
- pred_taken  out  1  predicted direction (counter MSB)
- pred_hist  out  HIST_BITS  history used for this prediction
- upd_valid  in  1  resolved-branch update
- upd_pc  in  PC_BITS  update index
- upd_taken  in  1  resolved direction
- upd_ready  out  1  high only in RUN
- init_busy  out  1  high in INIT

## Operation
- FSM states: INIT, RUN.
  - Reset forces INIT with idx=0.
  - INIT writes one index per cycle:
    - LHT[idx] gets 0 if idx < 2^PC_BITS;
    - LPT[idx] gets INIT_CTR = 2^(CTR_BITS-1)-1 (weakly not-taken) if idx < 2^HIST_BITS.
  - INIT lasts 2^max(PC_BITS,HIST_BITS) cycles, then RUN. RUN is terminal until reset.
- In INIT, pred_ready and upd_ready are 0. pred_valid and upd_valid are ignored: no state change, no pred_out_valid.
- Predict is accepted on pred_valid & pred_ready.
  - Stage 1 registers h = LHT[pred_pc] together with a valid bit.
  - Stage 2 registers pred_taken = LPT[h][CTR_BITS-1] and pred_hist = h, and asserts pred_out_valid.
  - Fully pipelined, one request per cycle, no backpressure on outputs.
- Update is accepted on upd_valid & upd_ready and completes in one edge, with h = LHT[upd_pc] read combinationally:
  - LHT[upd_pc] <= {h[HIST_BITS-2:0], upd_taken};
  - LPT[h] saturating update: +1 if taken and not at all-ones, -1 if not taken and not 0, otherwise unchanged.
- Simultaneous predict and update are independent. No bypass: each predict stage reads table contents from before that edge's update write.
- Histories with HIST_BITS > PC_BITS are legal; only LPT uses the full history index.

## Timing
- Reset values:
  - pred_out_valid = 0, pred_taken = 0, pred_hist = 0;
  - pred_ready = 0, upd_ready = 0;
  - init_busy = 1; FSM = INIT; pipeline valids = 0.
- Table storage is not reset asynchronously. The INIT sweep clears it.
- Init length, defaults: 1024 cycles.
  - init_busy falls, and both ready signals rise, in the cycle after the last index is written.
- Predict latency: request accepted at edge N; pred_out_valid is high for exactly the cycle after edge N+1.
- Update takes effect at the accepting edge. A predict accepted at that same edge sees the old history. A predict accepted one edge later sees the new history.
- Back-to-back updates to the same PC chain correctly, since each reads the previously written LHT entry.
- Reset mid-INIT restarts the sweep at idx 0.
- Reset mid-RUN:
  - drops in-flight predictions, with no pred_out_valid for them;
  - re-runs the full INIT sweep.

## Structure
- Package local_pred_pkg holds:
  - state_t enum {INIT, RUN};
  - function init_ctr(CTR_BITS);
  - function sat_update(ctr, taken), parametrised by width.
- Sub-module local_hist_table holds the LHT array:
  - combinational read port for predict;
  - combinational read port for update;
  - one write port, muxed between the init sweep and update shift.
- LPT storage, the FSM and the predict pipeline live in the top.

## Test plan
- Init gating: defaults; pred_valid=1 with pred_pc=5 during all 1024 INIT cycles -> no pred_out_valid, init_busy=1 throughout; ready signals rise in cycle 1025.
- Cold prediction: after init, predict pc=5 -> pred_out_valid 2 edges later, pred_taken=0, pred_hist=0x000.
- Training: 11 consecutive taken updates to pc=5, then predict pc=5 -> pred_hist=0x3FF, LPT[0x3FF]=4, pred_taken=1. After only 10 updates the same predict gives pred_taken=0.
- Saturation: 12 more taken updates to pc=5 -> LPT[0x3FF]=7, not 8. Then 1 not-taken update -> LPT[0x3FF]=6, LHT[5]=0x3FE.
- Same-cycle collision: predict and taken update to pc=9 (history 0x000) at the same edge -> pred_hist=0x000. Predict at the next edge -> pred_hist=0x001.
- Reset mid-operation: assert reset with predictions in flight and again at INIT cycle 100 -> no stale pred_out_valid, full 1024-cycle sweep, LHT[5]=0 afterwards.

Source files
------------

// File: rtl/local_pred_pkg.sv
// -----------------------------------------------------------------------------
// local_pred_pkg
// Shared types and helpers for the local-history branch predictor.
//   state_t    : controller states (INIT sweep, RUN)
//   init_ctr   : reset value of an LPT counter (weakly not-taken)
//   sat_update : saturating up/down counter step for any width up to 32
// -----------------------------------------------------------------------------
package local_pred_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int unsigned init_ctr(input int unsigned ctr_bits);
    return (32'd1 << (ctr_bits - 1)) - 32'd1;
  endfunction

  // Counter value is carried zero-extended in 32 bits; caller truncates.
  function automatic logic [31:0] sat_update(input logic [31:0] ctr,
                                             input logic        taken,
                                             input int unsigned ctr_bits);
    logic [31:0] max_v;
    max_v = (ctr_bits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << ctr_bits) - 32'd1);
    if (taken && (ctr != max_v))
      return ctr + 32'd1;
    else if (!taken && (ctr != 32'd0))
      return ctr - 32'd1;
    return ctr;
  endfunction

endpackage

// File: rtl/local_hist_table.sv
// -----------------------------------------------------------------------------
// local_hist_table
// Per-PC local history table (LHT). Storage is not reset; the owner clears it
// with an init sweep.
//   i_clk         : clock
//   i_pred_idx    : predict read index   -> o_pred_hist (combinational)
//   i_upd_idx     : update read index    -> o_upd_hist  (combinational)
//   i_init_we     : init sweep write, clears entry i_init_idx
//   i_upd_we      : update write, shifts i_upd_taken into entry i_upd_idx
// -----------------------------------------------------------------------------
module local_hist_table #(
  parameter int PC_BITS   = 10,
  parameter int HIST_BITS = 10
) (
  input  logic                 i_clk,
  input  logic [PC_BITS-1:0]   i_pred_idx,
  output logic [HIST_BITS-1:0] o_pred_hist,
  input  logic [PC_BITS-1:0]   i_upd_idx,
  output logic [HIST_BITS-1:0] o_upd_hist,
  input  logic                 i_init_we,
  input  logic [PC_BITS-1:0]   i_init_idx,
  input  logic                 i_upd_we,
  input  logic                 i_upd_taken
);

  logic [HIST_BITS-1:0] r_mem [2**PC_BITS];

  assign o_pred_hist = r_mem[i_pred_idx];
  assign o_upd_hist  = r_mem[i_upd_idx];

  // Init and update never overlap (update is only accepted in RUN).
  always_ff @(posedge i_clk) begin
    if (i_init_we)
      r_mem[i_init_idx] <= '0;
    else if (i_upd_we)
      r_mem[i_upd_idx] <= {o_upd_hist[HIST_BITS-2:0], i_upd_taken};
  end

endmodule

// File: rtl/local_predictor_pipe.sv
// -----------------------------------------------------------------------------
// local_predictor_pipe
// Pipelined local-history branch predictor: LHT (per-PC history) indexes
// LPT (saturating counters). After reset a sweep initialises both tables.
//
// state | meaning
// INIT  | sweeping idx over both tables, ports not ready
// RUN   | predict/update ports accepted; terminal until reset
//
// Ports:
//   i_clk, i_rst          : clock, asynchronous active-high reset
//   i_pred_valid/i_pred_pc, o_pred_ready : predict request handshake
//   o_pred_out_valid, o_pred_taken, o_pred_hist : predict result (2 edges later)
//   i_upd_valid/i_upd_pc/i_upd_taken, o_upd_ready : resolved-branch update
//   o_init_busy           : high during the init sweep
// -----------------------------------------------------------------------------
module local_predictor_pipe
  import local_pred_pkg::*;
#(
  parameter int PC_BITS   = 10,
  parameter int HIST_BITS = 10,
  parameter int CTR_BITS  = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_pred_valid,
  input  logic [PC_BITS-1:0]   i_pred_pc,
  output logic                 o_pred_ready,
  output logic                 o_pred_out_valid,
  output logic                 o_pred_taken,
  output logic [HIST_BITS-1:0] o_pred_hist,
  input  logic                 i_upd_valid,
  input  logic [PC_BITS-1:0]   i_upd_pc,
  input  logic                 i_upd_taken,
  output logic                 o_upd_ready,
  output logic                 o_init_busy
);

  localparam int IDX_BITS = (PC_BITS > HIST_BITS) ? PC_BITS : HIST_BITS;
  localparam logic [IDX_BITS-1:0] IDX_LAST = '1;
  localparam logic [CTR_BITS-1:0] INIT_CTR = CTR_BITS'(init_ctr(CTR_BITS));

  state_t               r_state;
  state_t               w_state_nxt;
  logic [IDX_BITS-1:0]  r_idx;
  logic                 w_init;
  logic                 w_pred_fire;
  logic                 w_upd_fire;
  logic                 w_lht_init_we;
  logic                 w_lpt_init_we;
  logic [HIST_BITS-1:0] w_lht_pred_hist;
  logic [HIST_BITS-1:0] w_lht_upd_hist;
  logic [CTR_BITS-1:0]  w_lpt_upd_ctr;

  logic                 r_s1_valid;
  logic [HIST_BITS-1:0] r_s1_hist;
  logic                 r_s2_valid;
  logic                 r_pred_taken;
  logic [HIST_BITS-1:0] r_pred_hist;

  logic [CTR_BITS-1:0]  r_lpt [2**HIST_BITS];

  // FSM: state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= INIT;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == INIT)
        r_idx <= r_idx + IDX_BITS'(1);
    end
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    if ((r_state == INIT) && (r_idx == IDX_LAST))
      w_state_nxt = RUN;
  end

  // FSM: outputs
  always_comb begin
    o_pred_ready = 1'b0;
    o_upd_ready  = 1'b0;
    o_init_busy  = 1'b1;
    if (r_state == RUN) begin
      o_pred_ready = 1'b1;
      o_upd_ready  = 1'b1;
      o_init_busy  = 1'b0;
    end
  end

  assign w_init      = (r_state == INIT);
  assign w_pred_fire = i_pred_valid & o_pred_ready;
  assign w_upd_fire  = i_upd_valid & o_upd_ready;

  // The sweep runs over the larger table; the smaller one only takes the
  // indices that fit it.
  if (IDX_BITS > PC_BITS) begin : g_lht_we_cut
    assign w_lht_init_we = w_init & ~|r_idx[IDX_BITS-1:PC_BITS];
  end else begin : g_lht_we_full
    assign w_lht_init_we = w_init;
  end

  if (IDX_BITS > HIST_BITS) begin : g_lpt_we_cut
    assign w_lpt_init_we = w_init & ~|r_idx[IDX_BITS-1:HIST_BITS];
  end else begin : g_lpt_we_full
    assign w_lpt_init_we = w_init;
  end

  local_hist_table #(
    .PC_BITS   (PC_BITS),
    .HIST_BITS (HIST_BITS)
  ) u_lht (
    .i_clk       (i_clk),
    .i_pred_idx  (i_pred_pc),
    .o_pred_hist (w_lht_pred_hist),
    .i_upd_idx   (i_upd_pc),
    .o_upd_hist  (w_lht_upd_hist),
    .i_init_we   (w_lht_init_we),
    .i_init_idx  (r_idx[PC_BITS-1:0]),
    .i_upd_we    (w_upd_fire),
    .i_upd_taken (i_upd_taken)
  );

  assign w_lpt_upd_ctr = CTR_BITS'(sat_update(32'(r_lpt[w_lht_upd_hist]),
                                              i_upd_taken, CTR_BITS));

  always_ff @(posedge i_clk) begin
    if (w_lpt_init_we)
      r_lpt[r_idx[HIST_BITS-1:0]] <= INIT_CTR;
    else if (w_upd_fire)
      r_lpt[w_lht_upd_hist] <= w_lpt_upd_ctr;
  end

  // Predict pipeline. Both stages read tables with nonblocking semantics, so
  // a same-edge update is never bypassed into the prediction.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_valid   <= 1'b0;
      r_s1_hist    <= '0;
      r_s2_valid   <= 1'b0;
      r_pred_taken <= 1'b0;
      r_pred_hist  <= '0;
    end else begin
      r_s1_valid <= w_pred_fire;
      if (w_pred_fire)
        r_s1_hist <= w_lht_pred_hist;
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_pred_taken <= r_lpt[r_s1_hist][CTR_BITS-1];
        r_pred_hist  <= r_s1_hist;
      end
    end
  end

  assign o_pred_out_valid = r_s2_valid;
  assign o_pred_taken     = r_pred_taken;
  assign o_pred_hist      = r_pred_hist;

endmodule

// File: tb/tb_local_predictor_pipe.sv
module tb_local_predictor_pipe;

  logic       clk;
  logic       rst;
  logic       pred_valid;
  logic [9:0] pred_pc;
  logic       pred_ready;
  logic       pred_out_valid;
  logic       pred_taken;
  logic [9:0] pred_hist;
  logic       upd_valid;
  logic [9:0] upd_pc;
  logic       upd_taken;
  logic       upd_ready;
  logic       init_busy;

  int total = 0;
  int bad   = 0;

  local_predictor_pipe #(
    .PC_BITS   (10),
    .HIST_BITS (10),
    .CTR_BITS  (3)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_pred_valid     (pred_valid),
    .i_pred_pc        (pred_pc),
    .o_pred_ready     (pred_ready),
    .o_pred_out_valid (pred_out_valid),
    .o_pred_taken     (pred_taken),
    .o_pred_hist      (pred_hist),
    .i_upd_valid      (upd_valid),
    .i_upd_pc         (upd_pc),
    .i_upd_taken      (upd_taken),
    .o_upd_ready      (upd_ready),
    .o_init_busy      (init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge just after reset release; leaves the bench at the
  // negedge following the last init edge with pred_valid dropped.
  task automatic init_sweep(input string tag);
    pred_valid = 1'b1;
    pred_pc    = 10'd5;
    for (int i = 0; i < 1024; i++) begin
      chk({tag, "_busy"},     32'(init_busy),      32'd1);
      chk({tag, "_outvalid"}, 32'(pred_out_valid), 32'd0);
      chk({tag, "_pready"},   32'(pred_ready),     32'd0);
      @(negedge clk);
    end
    pred_valid = 1'b0;
    chk({tag, "_busy_fall"}, 32'(init_busy),  32'd0);
    chk({tag, "_pready_up"}, 32'(pred_ready), 32'd1);
    chk({tag, "_uready_up"}, 32'(upd_ready),  32'd1);
    @(negedge clk);
    chk({tag, "_no_stale"}, 32'(pred_out_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_no_stale2"}, 32'(pred_out_valid), 32'd0);
  endtask

  task automatic pred(input string tag, input logic [9:0] pc,
                      input logic exp_taken, input logic [9:0] exp_hist);
    pred_valid = 1'b1;
    pred_pc    = pc;
    @(negedge clk);
    pred_valid = 1'b0;
    chk({tag, "_early"}, 32'(pred_out_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(pred_out_valid), 32'd1);
    chk({tag, "_taken"}, 32'(pred_taken),     32'(exp_taken));
    chk({tag, "_hist"},  32'(pred_hist),      32'(exp_hist));
    @(negedge clk);
    chk({tag, "_strobe"}, 32'(pred_out_valid), 32'd0);
  endtask

  task automatic upd(input logic [9:0] pc, input logic taken, input int n);
    upd_valid = 1'b1;
    upd_pc    = pc;
    upd_taken = taken;
    repeat (n) @(negedge clk);
    upd_valid = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    pred_valid = 1'b0;
    pred_pc    = '0;
    upd_valid  = 1'b0;
    upd_pc     = '0;
    upd_taken  = 1'b0;

    @(negedge clk);
    chk("rst_outvalid", 32'(pred_out_valid), 32'd0);
    chk("rst_taken",    32'(pred_taken),     32'd0);
    chk("rst_hist",     32'(pred_hist),      32'd0);
    chk("rst_pready",   32'(pred_ready),     32'd0);
    chk("rst_uready",   32'(upd_ready),      32'd0);
    chk("rst_busy",     32'(init_busy),      32'd1);
    rst = 1'b0;

    init_sweep("init1");

    // Cold prediction: history 0, counter 3 (011) -> not taken.
    pred("cold", 10'd5, 1'b0, 10'h000);

    // Training pc5: 10 taken fill history to 0x3FF, LPT[0x3FF] still 3.
    upd(10'd5, 1'b1, 10);
    pred("train10", 10'd5, 1'b0, 10'h3FF);
    upd(10'd5, 1'b1, 1);
    pred("train11", 10'd5, 1'b1, 10'h3FF);

    // Saturation: LPT[0x3FF] 4 -> 7 and held; one not-taken -> 6, LHT[5]=0x3FE.
    upd(10'd5, 1'b1, 12);
    pred("sat", 10'd5, 1'b1, 10'h3FF);
    upd(10'd5, 1'b0, 1);
    pred("nt_hist", 10'd5, 1'b0, 10'h3FE);

    // Probe LPT[0x3FF] through other PCs: 6, 5, 4 taken; 3 not taken.
    upd(10'd6, 1'b1, 10);
    pred("probe6", 10'd6, 1'b1, 10'h3FF);
    upd(10'd6, 1'b0, 1);
    upd(10'd7, 1'b1, 10);
    upd(10'd7, 1'b0, 1);
    upd(10'd8, 1'b1, 10);
    pred("probe4", 10'd8, 1'b1, 10'h3FF);
    upd(10'd8, 1'b0, 1);
    upd(10'd10, 1'b1, 10);
    pred("probe3", 10'd10, 1'b0, 10'h3FF);

    // Same-edge collision on pc9 (history 0); LPT[0] and LPT[1] saturated at 7.
    pred_valid = 1'b1;
    pred_pc    = 10'd9;
    upd_valid  = 1'b1;
    upd_pc     = 10'd9;
    upd_taken  = 1'b1;
    @(negedge clk);
    upd_valid = 1'b0;
    @(negedge clk);
    pred_valid = 1'b0;
    chk("coll_valid", 32'(pred_out_valid), 32'd1);
    chk("coll_hist",  32'(pred_hist),      32'h000);
    chk("coll_taken", 32'(pred_taken),     32'd1);
    @(negedge clk);
    chk("coll_next_valid", 32'(pred_out_valid), 32'd1);
    chk("coll_next_hist",  32'(pred_hist),      32'h001);
    chk("coll_next_taken", 32'(pred_taken),     32'd1);
    @(negedge clk);
    chk("coll_strobe", 32'(pred_out_valid), 32'd0);

    // Reset with a prediction in flight, then again 100 cycles into INIT.
    pred_valid = 1'b1;
    pred_pc    = 10'd5;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrun_outvalid", 32'(pred_out_valid), 32'd0);
    chk("midrun_busy",     32'(init_busy),      32'd1);
    @(negedge clk);
    chk("midrun_stale", 32'(pred_out_valid), 32'd0);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("midinit_busy", 32'(init_busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    init_sweep("init2");
    pred("after_rst", 10'd5, 1'b0, 10'h000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
